// File: rtl/mem_pkg.sv
// Shared definitions for the RAM initiator: FSM state encoding and the default
// RAM geometry used by mem_access_ctrl, ram and their benches.
package mem_pkg;

  localparam int DEF_BITS    = 32;
  localparam int DEF_ADDR    = 9;
  localparam int DEF_RAMSIZE = 512;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WRITE   = 3'd1,
    READ    = 3'd2,
    CAPTURE = 3'd3,
    DONE    = 3'd4
  } state_t;

endpackage

// File: rtl/mem_access_ctrl.sv
// CPU-side initiator for the single-port synchronous ram: one request at a time,
// MAR/MDR held internally, one-cycle RAM strobes and a one-cycle done pulse.
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int BITS    = DEF_BITS,
  parameter int ADDR    = DEF_ADDR,
  parameter int RAMSIZE = DEF_RAMSIZE
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            req,
  input  logic            we,
  input  logic [ADDR-1:0] addr,
  input  logic [BITS-1:0] wdata,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [BITS-1:0] rdata,
  output logic [ADDR-1:0] ram_address,
  output logic [BITS-1:0] ram_dataIn,
  output logic            ram_read,
  output logic            ram_write,
  input  logic [BITS-1:0] ram_dataOut
);

  state_t          state;
  logic [ADDR-1:0] mar;
  logic [BITS-1:0] mdr;

  // One extra bit so a RAMSIZE of exactly 2^ADDR is representable.
  function automatic logic out_of_range(input logic [ADDR-1:0] a);
    logic [ADDR:0] lim;
    lim = (ADDR+1)'(RAMSIZE);
    return ({1'b0, a} >= lim);
  endfunction

  // All outputs are registers updated alongside the state, so nothing on the
  // request side reaches the RAM pins combinationally.
  always_ff @(posedge clk) begin
    if (clr) begin
      state     <= IDLE;
      mar       <= '0;
      mdr       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      ram_read  <= 1'b0;
      ram_write <= 1'b0;
    end else begin
      done      <= 1'b0;
      ram_read  <= 1'b0;
      ram_write <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            mar  <= addr;
            busy <= 1'b1;
            if (out_of_range(addr)) begin
              state <= DONE;
              done  <= 1'b1;
              err   <= 1'b1;
            end else if (we) begin
              mdr       <= wdata;
              state     <= WRITE;
              ram_write <= 1'b1;
              err       <= 1'b0;
            end else begin
              state    <= READ;
              ram_read <= 1'b1;
              err      <= 1'b0;
            end
          end
        end
        WRITE: begin
          state <= DONE;
          done  <= 1'b1;
        end
        READ: begin
          state <= CAPTURE;
        end
        CAPTURE: begin
          // The RAM registered its output on the edge that ended READ.
          mdr   <= ram_dataOut;
          state <= DONE;
          done  <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          err   <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          err   <= 1'b0;
        end
      endcase
    end
  end

  assign rdata       = mdr;
  assign ram_address = mar;
  assign ram_dataIn  = mdr;

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

CPU-side initiator for the single-port synchronous `ram` (`BITS`/`ADDR`/`RAMSIZE`).
- Accepts one read or write request at a time from the control unit.
- Holds the target address in an internal MAR and the data in an internal MDR.
- Drives the RAM `dataIn`/`read`/`write`/`address` strobes for exactly one cycle, captures `dataOut` on reads, and signals completion with a one-cycle `done` pulse.
- Sits between the control unit/bus and `ram`; it is the only master of the RAM ports.

## Interface
- BITS, 32, data width (matches `ram`)
- ADDR, 9, address width (matches `ram`)
- RAMSIZE, 512, number of valid words; addresses ≥ RAMSIZE are rejected
- clk  in  1  system clock, all state changes on rising edge
- clr  in  1  reset: synchronous, active-high
- req  in  1  request; sampled only in IDLE
- we  in  1  1 = write, 0 = read; sampled with req
- addr  in  ADDR  word address; sampled with req
- wdata  in  BITS  write data; sampled with req when we=1
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- err  out  1  valid with done; 1 = address out of range, no RAM access made
- rdata  out  BITS  MDR contents; read data valid from the done cycle until the next accepted request
- ram_address  out  ADDR  to `ram.address` (= MAR)
- ram_dataIn  out  BITS  to `ram.dataIn` (= MDR)
- ram_read  out  1  to `ram.read`
- ram_write  out  1  to `ram.write`
- ram_dataOut  in  BITS  from `ram.dataOut`

## Operation
FSM states and transitions:
- IDLE: if req, latch MAR←addr, then branch:
  - addr ≥ RAMSIZE: go to DONE with err set.
  - we=1: MDR←wdata, go to WRITE.
  - we=0: go to READ.
- WRITE: ram_write=1 for this cycle only → DONE.
- READ: ram_read=1 for this cycle only → CAPTURE.
- CAPTURE: MDR←ram_dataOut (the RAM registers read data on the edge that ends READ) → DONE.
- DONE: done=1; err reflects the range check → IDLE.

Rules:
- req is ignored in every state but IDLE, including DONE. A back-to-back request is accepted at the earliest in the cycle after DONE.
- All outputs are Moore (decoded from registered state, MAR and MDR); no combinational path from req to the ram_* outputs.
- ram_read and ram_write are never high in the same cycle. Neither is high outside READ/WRITE.
- A write leaves MDR = wdata, so rdata shows the written value after a write.
- An err request leaves MDR unchanged; MAR still captures addr.
- Range check compares addr in ADDR+1 bits against RAMSIZE. With defaults it never fires; it must fire when RAMSIZE < 2^ADDR.

## Timing
- Reset values: state=IDLE, MAR=0, MDR=0.
- Reset outputs: busy=0, done=0, err=0, rdata=0, ram_address=0, ram_dataIn=0, ram_read=0, ram_write=0.
- Request accepted on edge E0. Edges E1, E2, E3 are the next three rising edges; "cycle after Ek" means the clock period that begins at Ek.
- Write: WRITE occupies the cycle after E0; done is high in the cycle after E1; latency is 2 cycles.
- Read: READ occupies the cycle after E0, CAPTURE the cycle after E1; done is high in the cycle after E2, with rdata valid then; latency is 3 cycles.
- Error: done=1 and err=1 in the cycle after E0; latency is 1 cycle.
- busy rises in the cycle after E0 and falls in the cycle after the DONE cycle.
- clr asserted at any edge, including mid-WRITE or mid-READ, forces the reset values at that edge. Strobes drop immediately after that edge; the aborted request produces no done.
- clr has priority over req on the same edge.

## Structure
- Shared package `mem_pkg`:
  - state enum {IDLE, WRITE, READ, CAPTURE, DONE}
  - default BITS/ADDR/RAMSIZE constants, shared with `ram` and its bench
- No sub-module: MAR, MDR and the FSM are inline registers. The block is self-contained at roughly 120–180 lines.

## Test plan
- Reset: clr=1 for 2 cycles → all outputs 0, busy=0. With clr still high, req=1 → no strobes.
- Write then read:
  - req, we=1, addr=3, wdata=5 → ram_write=1 with ram_address=3, ram_dataIn=5 for exactly one cycle; done 2 cycles after acceptance.
  - Then req, we=0, addr=3 → ram_read one cycle; done 3 cycles after acceptance with rdata=5, err=0.
- Back-to-back: hold req=1 continuously while alternating writes to addr 0/511 with 'hDEADBEEF/'h1 and reads from them → each request accepted only from IDLE; no strobes overlap; reads return the written values.
- Out of range: instantiate with RAMSIZE=256, then req, we=0, addr=300 → done=1, err=1 one cycle after acceptance; ram_read and ram_write never asserted; rdata unchanged.
- Reset mid-read: accept a read of addr 7, then assert clr during CAPTURE → next cycle state IDLE, rdata=0, no done pulse. A subsequent read of addr 7 completes normally.
